hiss_lvds_seq: RTL and testbench
================================

Name: hiss_lvds_seq

Overview:
Power-up/power-down sequencer for the HISS LVDS pad macro in the padframe. It drives the macro's bias, replica, clock and per-lane enables in a fixed, timed order from a single power request. It reports a link-ready flag to the baseband/radio interface logic. Lane enables are gated so that no RX/TX lane is enabled before bias, replica and clock have settled.

Parameters:
BIAS_CYC, 16, cycles hiss_biasen held before hiss_replien asserts (min 1)
REPLI_CYC, 8, cycles hiss_replien held before hiss_clken asserts (min 1)
CLK_CYC, 4, cycles hiss_clken held before lanes enable (min 1)
DRAIN_CYC, 4, cycles after lane disable before clock/replica/bias drop (min 1)
CNT_W, 8, settle counter width; every *_CYC must be ≤ 2^CNT_W-1

Ports:
clk  in  1  sequencer clock, free-running
rst  in  1  synchronous, active-high reset
pwr_req  in  1  level request: 1 = link up, 0 = link down
lane_cfg  in  4  lane enable mask {txq, txi, rxq, rxi}, sampled every cycle in ACTIVE
hiss_biasen  out  1  to macro bias enable
hiss_replien  out  1  to macro replica enable
hiss_clken  out  1  to macro clock-lane driver enable
hiss_rxien  out  1  RX-I lane driver enable
hiss_rxqen  out  1  RX-Q lane driver enable
hiss_txien  out  1  TX-I receiver enable
hiss_txqen  out  1  TX-Q receiver enable
link_ready  out  1  1 only in ACTIVE
seq_state  out  3  current state encoding (debug/status)

Behaviour:
- All outputs are registered. Reset (rst=1 at a clk edge) forces state OFF, counter 0, and every output 0 on the next edge, regardless of the current state.
- States/encodings: OFF=0, BIAS=1, REPLI=2, CLKUP=3, ACTIVE=4, DRAIN=5, DOWN=6.
- OFF: all enables 0. pwr_req=1 -> BIAS, counter cleared.
- BIAS: biasen=1. Counter increments each cycle. When counter==BIAS_CYC-1 and pwr_req=1 -> REPLI, counter cleared.
- REPLI: biasen and replien=1. Counter reaches REPLI_CYC-1 -> CLKUP.
- CLKUP: biasen, replien and clken=1. Counter reaches CLK_CYC-1 -> ACTIVE.
- ACTIVE: biasen, replien and clken=1. Lane enables = lane_cfg registered, with 1-cycle latency from lane_cfg to pins. link_ready=1. pwr_req=0 -> DRAIN.
- DRAIN: all four lane enables 0 on entry. clken, replien and biasen stay 1. Counter reaches DRAIN_CYC-1 -> DOWN.
- DOWN: clken=0, replien=0, biasen=1 for exactly one cycle, then -> OFF (biasen drops last).
- pwr_req drops during BIAS, REPLI or CLKUP: abort to DOWN on the next edge, skipping DRAIN because no lane was enabled.
- pwr_req reasserts during DRAIN or DOWN: the sequence still completes to OFF, then restarts from BIAS on the following cycle. There is no shortcut back to ACTIVE.
- Settle timing: a power-up from OFF asserts biasen on the first edge where pwr_req=1 is seen. link_ready rises BIAS_CYC+REPLI_CYC+CLK_CYC edges later.
- Settle timing: power-down from ACTIVE takes DRAIN_CYC+1 cycles to reach OFF.
- Invariants, never violated in any cycle:
  - replien implies biasen.
  - clken implies replien.
  - any lane enable implies clken, and the state is ACTIVE.
- lane_cfg changes in ACTIVE: the new mask is applied next cycle. lane_cfg is ignored in every other state.
- Counter: unsigned CNT_W bits, cleared on every state change. It never wraps because terminal counts are bounded by the parameter rule.

Decomposition:
- Package hiss_lvds_pkg holds:
  - the state encoding constants (OFF..DOWN);
  - lane_cfg bit index constants (RXI=0, RXQ=1, TXI=2, TXQ=3);
  - default *_CYC values.
- One sub-module, hiss_settle_cnt: a clearable up-counter with terminal-count compare (inputs clr, tc_val; output done). The FSM and output decode stay in the top module.

Test Plan:
1. Power-up, defaults: rst pulse, then pwr_req=1, lane_cfg=4'hF -> biasen at edge 1, replien at edge 17, clken at edge 25, link_ready and all lane enables at edge 29.
2. Orderly power-down: from ACTIVE, pwr_req=0 -> lanes go 0 next edge, clken/replien drop 4 cycles later, biasen drops 1 cycle after that, seq_state returns to 0.
3. Abort mid-power-up: pwr_req=0 during REPLI (cycle 20) -> DOWN next edge, then OFF; no lane enable or clken ever asserted.
4. Lane reconfiguration: in ACTIVE, lane_cfg 4'hF -> 4'h5 -> rxi and txi stay 1, rxq and txq drop exactly 1 cycle later; link_ready stays 1.
5. Reset mid-operation: rst=1 while ACTIVE -> all outputs 0 and seq_state=0 on the next edge. pwr_req still 1 after reset release -> sequence restarts from BIAS.
6. Request bounce: pwr_req 1->0->1 during DRAIN -> completes to OFF, then BIAS on the next cycle. An invariant checker flags zero violations across the whole run.

Source files
------------

// File: rtl/hiss_lvds_seq_pkg.sv
// hiss_lvds_pkg: shared constants for the HISS LVDS pad-macro sequencer.
//   - sequencer state encodings (OFF..DOWN), also visible on seq_state
//   - lane_cfg / lane-enable bit positions
//   - default settle times
//   - pad_en_t: the registered pad-enable bundle and its per-state decode
package hiss_lvds_pkg;

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_BIAS   = 3'd1;
  localparam logic [2:0] ST_REPLI  = 3'd2;
  localparam logic [2:0] ST_CLKUP  = 3'd3;
  localparam logic [2:0] ST_ACTIVE = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_DOWN   = 3'd6;

  localparam int NUM_LANES = 4;
  localparam int RXI = 0;
  localparam int RXQ = 1;
  localparam int TXI = 2;
  localparam int TXQ = 3;

  localparam int BIAS_CYC_DEF  = 16;
  localparam int REPLI_CYC_DEF = 8;
  localparam int CLK_CYC_DEF   = 4;
  localparam int DRAIN_CYC_DEF = 4;
  localparam int CNT_W_DEF     = 8;

  typedef struct packed {
    logic                 biasen;
    logic                 replien;
    logic                 clken;
    logic [NUM_LANES-1:0] lane;
    logic                 link_ready;
  } pad_en_t;

  // Enables that must be on the pins while in state st. Lanes only pass
  // through in ACTIVE, so the bias->replica->clock->lane nesting holds by
  // construction for every state.
  function automatic pad_en_t pad_decode(input logic [2:0] st,
                                         input logic [NUM_LANES-1:0] cfg);
    pad_en_t p;
    p            = '0;
    p.biasen     = (st != ST_OFF) && (st <= ST_DOWN);
    p.replien    = (st >= ST_REPLI) && (st <= ST_DRAIN);
    p.clken      = (st >= ST_CLKUP) && (st <= ST_DRAIN);
    p.lane       = (st == ST_ACTIVE) ? cfg : '0;
    p.link_ready = (st == ST_ACTIVE);
    return p;
  endfunction

endpackage

// File: rtl/hiss_lvds_seq_if.sv
// hiss_lvds_if: request side and pad side of the LVDS sequencer.
//   master : power-request owner (drives pwr_req, lane_cfg; observes pads)
//   slave  : the sequencer (drives macro enables, link_ready, seq_state)
interface hiss_lvds_if;
  import hiss_lvds_pkg::*;

  logic                 pwr_req;
  logic [NUM_LANES-1:0] lane_cfg;     // {txq, txi, rxq, rxi}
  logic                 hiss_biasen;
  logic                 hiss_replien;
  logic                 hiss_clken;
  logic                 hiss_rxien;
  logic                 hiss_rxqen;
  logic                 hiss_txien;
  logic                 hiss_txqen;
  logic                 link_ready;
  logic [2:0]           seq_state;

  modport master (
    output pwr_req, lane_cfg,
    input  hiss_biasen, hiss_replien, hiss_clken,
           hiss_rxien, hiss_rxqen, hiss_txien, hiss_txqen,
           link_ready, seq_state
  );

  modport slave (
    input  pwr_req, lane_cfg,
    output hiss_biasen, hiss_replien, hiss_clken,
           hiss_rxien, hiss_rxqen, hiss_txien, hiss_txqen,
           link_ready, seq_state
  );
endinterface

// File: rtl/hiss_settle_cnt.sv
// hiss_settle_cnt: clearable up-counter with terminal-count compare.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart from 0 on the next edge (state change)
//   tc_val   : terminal count for the current state
//   done     : cnt == tc_val
// The counter holds at tc_val instead of running on, so it never wraps in
// states that wait on pwr_req rather than on time.
module hiss_settle_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  assign done = (cnt == tc_val);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (!done) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hiss_lvds_seq.sv
// hiss_lvds_seq: power-up/power-down sequencer for the HISS LVDS pad macro.
//   clk, rst : free-running clock, synchronous active-high reset
//   bus      : hiss_lvds_if.slave
//     pwr_req      level request, 1 = link up
//     lane_cfg     {txq, txi, rxq, rxi} lane mask, followed only in ACTIVE
//     hiss_*en     macro bias / replica / clock / lane enables (registered)
//     link_ready   1 only in ACTIVE
//     seq_state    current state encoding
// Up:   OFF -> BIAS -> REPLI -> CLKUP -> ACTIVE, each step timed.
// Down: ACTIVE -> DRAIN -> DOWN -> OFF; an abort during power-up goes
//       straight to DOWN since no lane was ever enabled.
module hiss_lvds_seq
  import hiss_lvds_pkg::*;
#(
  parameter int BIAS_CYC  = BIAS_CYC_DEF,
  parameter int REPLI_CYC = REPLI_CYC_DEF,
  parameter int CLK_CYC   = CLK_CYC_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  hiss_lvds_if.slave  bus
);
  logic [2:0]       state, nxt;
  logic [CNT_W-1:0] tc_val;
  logic             done;
  pad_en_t          pad_q;

  always_comb begin
    tc_val = '0;
    case (state)
      ST_BIAS:  tc_val = CNT_W'(BIAS_CYC - 1);
      ST_REPLI: tc_val = CNT_W'(REPLI_CYC - 1);
      ST_CLKUP: tc_val = CNT_W'(CLK_CYC - 1);
      ST_DRAIN: tc_val = CNT_W'(DRAIN_CYC - 1);
      default:  tc_val = '0;
    endcase
  end

  // Dropping pwr_req during power-up wins over the settle count.
  always_comb begin
    nxt = state;
    case (state)
      ST_OFF:    if (bus.pwr_req) nxt = ST_BIAS;
      ST_BIAS:   if (!bus.pwr_req) nxt = ST_DOWN;
                 else if (done)    nxt = ST_REPLI;
      ST_REPLI:  if (!bus.pwr_req) nxt = ST_DOWN;
                 else if (done)    nxt = ST_CLKUP;
      ST_CLKUP:  if (!bus.pwr_req) nxt = ST_DOWN;
                 else if (done)    nxt = ST_ACTIVE;
      ST_ACTIVE: if (!bus.pwr_req) nxt = ST_DRAIN;
      ST_DRAIN:  if (done) nxt = ST_DOWN;
      ST_DOWN:   nxt = ST_OFF;
      default:   nxt = ST_OFF;
    endcase
  end

  hiss_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (nxt != state),
    .tc_val (tc_val),
    .done   (done)
  );

  // Pad enables are registered from the next state so they change on the
  // same edge as seq_state; lane_cfg thus reaches the pins one edge after
  // it is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      pad_q <= '0;
    end else begin
      state <= nxt;
      pad_q <= pad_decode(nxt, bus.lane_cfg);
    end
  end

  assign bus.hiss_biasen  = pad_q.biasen;
  assign bus.hiss_replien = pad_q.replien;
  assign bus.hiss_clken   = pad_q.clken;
  assign bus.hiss_rxien   = pad_q.lane[RXI];
  assign bus.hiss_rxqen   = pad_q.lane[RXQ];
  assign bus.hiss_txien   = pad_q.lane[TXI];
  assign bus.hiss_txqen   = pad_q.lane[TXQ];
  assign bus.link_ready   = pad_q.link_ready;
  assign bus.seq_state    = state;
endmodule

// File: tb/tb_hiss_lvds_seq.sv
module tb_hiss_lvds_seq;
  import hiss_lvds_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;

  always #5 clk = ~clk;

  hiss_lvds_if bif ();
  hiss_lvds_seq u_dut (.clk(clk), .rst(rst), .bus(bif));

  wire [3:0] lanes = {bif.hiss_txqen, bif.hiss_txien, bif.hiss_rxqen, bif.hiss_rxien};
  wire [3:0] core  = {bif.hiss_biasen, bif.hiss_replien, bif.hiss_clken, bif.link_ready};

  // Enable-nesting invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (bif.hiss_replien && !bif.hiss_biasen) viol++;
    if (bif.hiss_clken && !bif.hiss_replien) viol++;
    if ((|lanes) && (!bif.hiss_clken || bif.seq_state != ST_ACTIVE)) viol++;
    if (bif.link_ready != (bif.seq_state == ST_ACTIVE)) viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time=%0t required < 200000", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bif.pwr_req = 1'b0; bif.lane_cfg = 4'h0;
    tick; tick;
    total++; if ({core, lanes} !== 8'h00) begin bad++; $display("FAIL reset_outs: got=%h exp=00", {core, lanes}); end
    total++; if (bif.seq_state !== ST_OFF) begin bad++; $display("FAIL reset_state: got=%0d exp=0", bif.seq_state); end
    rst = 1'b0;
    tick;
    total++; if (bif.seq_state !== ST_OFF || core !== 4'h0) begin bad++; $display("FAIL idle_off: state=%0d core=%h exp 0/0", bif.seq_state, core); end
  endtask

  task automatic test_power_up;
    int e_b, e_r, e_c, e_l, e_n;
    e_b = 0; e_r = 0; e_c = 0; e_l = 0; e_n = 0;
    bif.pwr_req = 1'b1; bif.lane_cfg = 4'hF;
    for (int e = 1; e <= 40; e++) begin
      tick;
      if (bif.hiss_biasen  && e_b == 0) e_b = e;
      if (bif.hiss_replien && e_r == 0) e_r = e;
      if (bif.hiss_clken   && e_c == 0) e_c = e;
      if (bif.link_ready   && e_l == 0) e_l = e;
      if ((lanes == 4'hF)  && e_n == 0) e_n = e;
    end
    total++; if (e_b !== 1)  begin bad++; $display("FAIL up_biasen_edge: got=%0d exp=1", e_b); end
    total++; if (e_r !== 17) begin bad++; $display("FAIL up_replien_edge: got=%0d exp=17", e_r); end
    total++; if (e_c !== 25) begin bad++; $display("FAIL up_clken_edge: got=%0d exp=25", e_c); end
    total++; if (e_l !== 29) begin bad++; $display("FAIL up_link_ready_edge: got=%0d exp=29", e_l); end
    total++; if (e_n !== 29) begin bad++; $display("FAIL up_lanes_edge: got=%0d exp=29", e_n); end
    total++; if (bif.seq_state !== ST_ACTIVE) begin bad++; $display("FAIL up_state: got=%0d exp=4", bif.seq_state); end
  endtask

  task automatic test_power_down;
    bif.pwr_req = 1'b0;
    tick;
    total++; if (lanes !== 4'h0 || core !== 4'hE || bif.seq_state !== ST_DRAIN) begin
      bad++; $display("FAIL dn_drain_entry: lanes=%h core=%h state=%0d exp 0/e/5", lanes, core, bif.seq_state); end
    tick; tick; tick;
    total++; if (core !== 4'hE || bif.seq_state !== ST_DRAIN) begin
      bad++; $display("FAIL dn_drain_hold: core=%h state=%0d exp e/5", core, bif.seq_state); end
    tick;
    total++; if (core !== 4'h8 || bif.seq_state !== ST_DOWN) begin
      bad++; $display("FAIL dn_down: core=%h state=%0d exp 8/6", core, bif.seq_state); end
    tick;
    total++; if (core !== 4'h0 || bif.seq_state !== ST_OFF) begin
      bad++; $display("FAIL dn_off: core=%h state=%0d exp 0/0", core, bif.seq_state); end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 1'b0;
    bif.pwr_req = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick;
      seen |= bif.hiss_clken | (|lanes);
    end
    total++; if (bif.seq_state !== ST_REPLI) begin bad++; $display("FAIL ab_repli: got=%0d exp=2", bif.seq_state); end
    bif.pwr_req = 1'b0;
    tick;
    seen |= bif.hiss_clken | (|lanes);
    total++; if (bif.seq_state !== ST_DOWN || core !== 4'h8) begin
      bad++; $display("FAIL ab_down: state=%0d core=%h exp 6/8", bif.seq_state, core); end
    tick;
    seen |= bif.hiss_clken | (|lanes);
    total++; if (bif.seq_state !== ST_OFF || core !== 4'h0) begin
      bad++; $display("FAIL ab_off: state=%0d core=%h exp 0/0", bif.seq_state, core); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ab_no_clk_lane: got=%b exp=0", seen); end
  endtask

  task automatic test_lane_reconfig;
    bif.pwr_req = 1'b1; bif.lane_cfg = 4'hF;
    repeat (29) tick;
    total++; if (bif.seq_state !== ST_ACTIVE || lanes !== 4'hF) begin
      bad++; $display("FAIL lc_active: state=%0d lanes=%h exp 4/f", bif.seq_state, lanes); end
    bif.lane_cfg = 4'h5;
    #1;
    total++; if (lanes !== 4'hF) begin bad++; $display("FAIL lc_no_comb_path: got=%h exp=f", lanes); end
    tick;
    total++; if (lanes !== 4'h5 || bif.link_ready !== 1'b1) begin
      bad++; $display("FAIL lc_mask5: lanes=%h link=%b exp 5/1", lanes, bif.link_ready); end
    bif.lane_cfg = 4'hA;
    tick;
    total++; if (lanes !== 4'hA || bif.link_ready !== 1'b1) begin
      bad++; $display("FAIL lc_maskA: lanes=%h link=%b exp a/1", lanes, bif.link_ready); end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    tick;
    total++; if ({core, lanes} !== 8'h00 || bif.seq_state !== ST_OFF) begin
      bad++; $display("FAIL rm_reset: outs=%h state=%0d exp 00/0", {core, lanes}, bif.seq_state); end
    rst = 1'b0;
    tick;
    total++; if (bif.seq_state !== ST_BIAS || core !== 4'h8) begin
      bad++; $display("FAIL rm_restart: state=%0d core=%h exp 1/8", bif.seq_state, core); end
  endtask

  task automatic test_back_to_back;
    bif.lane_cfg = 4'h3;
    repeat (28) tick;
    total++; if (bif.seq_state !== ST_ACTIVE || lanes !== 4'h3) begin
      bad++; $display("FAIL bb_active: state=%0d lanes=%h exp 4/3", bif.seq_state, lanes); end
    bif.pwr_req = 1'b0;
    tick;
    tick;
    bif.pwr_req = 1'b1;
    tick; tick;
    total++; if (bif.seq_state !== ST_DRAIN || lanes !== 4'h0) begin
      bad++; $display("FAIL bb_drain: state=%0d lanes=%h exp 5/0", bif.seq_state, lanes); end
    tick;
    total++; if (bif.seq_state !== ST_DOWN) begin bad++; $display("FAIL bb_down: got=%0d exp=6", bif.seq_state); end
    tick;
    total++; if (bif.seq_state !== ST_OFF || core !== 4'h0) begin
      bad++; $display("FAIL bb_off: state=%0d core=%h exp 0/0", bif.seq_state, core); end
    tick;
    total++; if (bif.seq_state !== ST_BIAS || core !== 4'h8) begin
      bad++; $display("FAIL bb_rebias: state=%0d core=%h exp 1/8", bif.seq_state, core); end
    tick;
    total++; if (viol !== 0) begin bad++; $display("FAIL invariants: violations=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_power_down;
    test_abort;
    test_lane_reconfig;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
